// File: rtl/watch_ctrl_ma.sv
// Digital watch controller: BCD time of day, NUM_ALARMS alarms with ring
// timeout, stopwatch with split, and a mode/set/clear button interface.
module watch_ctrl_ma #(
  parameter int NUM_ALARMS = 2,
  parameter int TIMEOUT_S  = 15,
  parameter int RING_S     = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sec_tick,
  input  logic                  mode_btn,
  input  logic                  set_btn,
  input  logic                  clr_btn,
  output logic [3:0]            hh_t,
  output logic [3:0]            hh_u,
  output logic [3:0]            mm_t,
  output logic [3:0]            mm_u,
  output logic [3:0]            ss_t,
  output logic [3:0]            ss_u,
  output logic [3:0]            ah_t,
  output logic [3:0]            ah_u,
  output logic [3:0]            am_t,
  output logic [3:0]            am_u,
  output logic [NUM_ALARMS-1:0] alarm_en,
  output logic                  ring,
  output logic [1:0]            ring_idx,
  output logic [6:0]            sw_mm,
  output logic [5:0]            sw_ss,
  output logic [1:0]            state_out,
  output logic [2:0]            edit_sel,
  output logic [1:0]            alarm_idx,
  output logic [1:0]            sw_state_out
);

  typedef enum logic [1:0] {
    ST_NORMAL    = 2'd0,
    ST_SET_TIME  = 2'd1,
    ST_SET_ALARM = 2'd2,
    ST_STOPWATCH = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SW_IDLE  = 2'd0,
    SW_RUN   = 2'd1,
    SW_SPLIT = 2'd2,
    SW_STOP  = 2'd3
  } sw_state_t;

  localparam int TO_W   = $clog2(TIMEOUT_S + 1);
  localparam int RING_W = $clog2(RING_S + 1);
  localparam logic [1:0]        LAST_ALARM = 2'(NUM_ALARMS - 1);
  localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(TIMEOUT_S - 1);
  localparam logic [RING_W-1:0] RING_LAST  = RING_W'(RING_S - 1);

  // Increment one field of a packed {hh_t,hh_u,mm_t,mm_u} value with the
  // per-digit wrap limits; hh_u is clamped when hh_t rolls into 2.
  function automatic logic [15:0] inc_field(input logic [2:0] sel, input logic [15:0] v);
    logic [3:0] ht, hu, mt, mu;
    {ht, hu, mt, mu} = v;
    case (sel)
      3'd0: begin
        ht = (ht >= 4'd2) ? 4'd0 : ht + 4'd1;
        if (ht == 4'd2 && hu > 4'd3) hu = 4'd3;
      end
      3'd1: begin
        if (hu >= ((ht == 4'd2) ? 4'd3 : 4'd9)) hu = 4'd0;
        else hu = hu + 4'd1;
      end
      3'd2: mt = (mt >= 4'd5) ? 4'd0 : mt + 4'd1;
      3'd3: mu = (mu >= 4'd9) ? 4'd0 : mu + 4'd1;
      default: ;
    endcase
    return {ht, hu, mt, mu};
  endfunction

  // One-second advance of a packed BCD hh:mm:ss value, 23:59:59 -> 00:00:00.
  function automatic logic [23:0] next_time(input logic [23:0] t);
    logic [3:0] ht, hu, mt, mu, st, su;
    logic c_m, c_h;
    {ht, hu, mt, mu, st, su} = t;
    c_m = 1'b0;
    c_h = 1'b0;
    if (su == 4'd9) begin
      su = 4'd0;
      if (st == 4'd5) begin
        st  = 4'd0;
        c_m = 1'b1;
      end else begin
        st = st + 4'd1;
      end
    end else begin
      su = su + 4'd1;
    end
    if (c_m) begin
      if (mu == 4'd9) begin
        mu = 4'd0;
        if (mt == 4'd5) begin
          mt  = 4'd0;
          c_h = 1'b1;
        end else begin
          mt = mt + 4'd1;
        end
      end else begin
        mu = mu + 4'd1;
      end
    end
    if (c_h) begin
      if (ht == 4'd2 && hu == 4'd3) begin
        ht = 4'd0;
        hu = 4'd0;
      end else if (hu == 4'd9) begin
        hu = 4'd0;
        ht = ht + 4'd1;
      end else begin
        hu = hu + 4'd1;
      end
    end
    return {ht, hu, mt, mu, st, su};
  endfunction

  // Registers
  logic                r_mode_q, r_set_q, r_clr_q;
  state_t              r_state;
  logic [2:0]          r_edit_sel;
  logic [1:0]          r_alarm_idx;
  logic [TO_W-1:0]     r_to_cnt;
  logic [23:0]         r_time;
  logic                r_ring;
  logic [1:0]          r_ring_idx;
  logic [RING_W-1:0]   r_ring_cnt;
  sw_state_t           r_sw_state;
  logic [6:0]          r_sw_mm, r_sw_disp_mm;
  logic [5:0]          r_sw_ss, r_sw_disp_ss;

  // Combinational
  logic                w_mode_p, w_set_p, w_clr_p, w_any_p;
  logic                w_act_mode, w_act_set, w_act_clr;
  logic                w_in_set, w_timeout, w_adv, w_leave_set_time;
  state_t              w_state_next;
  logic [2:0]          w_edit_sel_next;
  logic [1:0]          w_alarm_idx_next;
  logic [TO_W-1:0]     w_to_cnt_next;
  logic [23:0]         w_time_nx;
  logic [3:0][15:0]    w_alarm_pad;
  logic [3:0]          w_en_pad;
  logic [3:0]          w_match;
  logic                w_ring_start;
  logic [1:0]          w_ring_idx_new;
  logic [15:0]         w_disp_alarm;
  sw_state_t           w_sw_state_next;
  logic                w_sw_clear, w_sw_split_enter, w_sw_counting;

  // Edge detection: every action below happens on a rising edge only.
  // A press while ringing only silences the ring.
  assign w_mode_p   = mode_btn & ~r_mode_q;
  assign w_set_p    = set_btn & ~r_set_q;
  assign w_clr_p    = clr_btn & ~r_clr_q;
  assign w_any_p    = w_mode_p | w_set_p | w_clr_p;
  assign w_act_mode = w_mode_p & ~r_ring;
  assign w_act_set  = w_set_p & ~w_mode_p & ~r_ring;
  assign w_act_clr  = w_clr_p & ~r_ring;

  assign w_in_set         = (r_state == ST_SET_TIME) || (r_state == ST_SET_ALARM);
  assign w_adv            = sec_tick && (r_state != ST_SET_TIME);
  assign w_leave_set_time = (r_state == ST_SET_TIME) && (w_state_next != ST_SET_TIME);
  assign w_time_nx        = next_time(r_time);

  // Button history registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mode_q <= 1'b0;
      r_set_q  <= 1'b0;
      r_clr_q  <= 1'b0;
    end else begin
      r_mode_q <= mode_btn;
      r_set_q  <= set_btn;
      r_clr_q  <= clr_btn;
    end
  end

  // Main FSM: next state, edit cursor and inactivity timeout
  always_comb begin
    w_state_next     = r_state;
    w_edit_sel_next  = r_edit_sel;
    w_alarm_idx_next = r_alarm_idx;
    w_to_cnt_next    = r_to_cnt;
    w_timeout        = 1'b0;
    if (!w_in_set || w_any_p) begin
      w_to_cnt_next = '0;
    end else if (sec_tick) begin
      if (r_to_cnt == TO_LAST) begin
        w_timeout     = 1'b1;
        w_to_cnt_next = '0;
      end else begin
        w_to_cnt_next = r_to_cnt + TO_W'(1);
      end
    end
    if (w_timeout) begin
      w_state_next     = ST_NORMAL;
      w_edit_sel_next  = 3'd0;
      w_alarm_idx_next = 2'd0;
    end else if (w_act_mode) begin
      case (r_state)
        ST_NORMAL: begin
          w_state_next    = ST_SET_TIME;
          w_edit_sel_next = 3'd0;
        end
        ST_SET_TIME: begin
          if (r_edit_sel >= 3'd3) begin
            w_state_next     = ST_SET_ALARM;
            w_edit_sel_next  = 3'd0;
            w_alarm_idx_next = 2'd0;
          end else begin
            w_edit_sel_next = r_edit_sel + 3'd1;
          end
        end
        ST_SET_ALARM: begin
          if (r_edit_sel >= 3'd4) begin
            w_edit_sel_next = 3'd0;
            if (r_alarm_idx < LAST_ALARM) begin
              w_alarm_idx_next = r_alarm_idx + 2'd1;
            end else begin
              w_state_next     = ST_STOPWATCH;
              w_alarm_idx_next = 2'd0;
            end
          end else begin
            w_edit_sel_next = r_edit_sel + 3'd1;
          end
        end
        ST_STOPWATCH: begin
          w_state_next    = ST_NORMAL;
          w_edit_sel_next = 3'd0;
        end
        default: w_state_next = ST_NORMAL;
      endcase
    end
  end

  // Main FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_NORMAL;
      r_edit_sel  <= 3'd0;
      r_alarm_idx <= 2'd0;
      r_to_cnt    <= '0;
    end else begin
      r_state     <= w_state_next;
      r_edit_sel  <= w_edit_sel_next;
      r_alarm_idx <= w_alarm_idx_next;
      r_to_cnt    <= w_to_cnt_next;
    end
  end

  // Time of day: frozen while being set, seconds zeroed on leaving set mode
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_time <= 24'h000000;
    end else if (w_leave_set_time) begin
      r_time[7:0] <= 8'h00;
    end else if (w_adv) begin
      r_time <= w_time_nx;
    end else if (w_act_set && r_state == ST_SET_TIME) begin
      r_time[23:8] <= inc_field(r_edit_sel, r_time[23:8]);
    end
  end

  // Alarm storage, padded to four slots so selection never indexes out of range
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_alarm
      if (gi < NUM_ALARMS) begin : g_on
        logic [15:0] r_alarm;
        logic        r_en;
        // Edit this alarm's digits or toggle its enable
        always_ff @(posedge clk) begin
          if (!rst) begin
            r_alarm <= 16'h0000;
            r_en    <= 1'b0;
          end else if (w_act_set && r_state == ST_SET_ALARM && r_alarm_idx == 2'(gi)) begin
            if (r_edit_sel == 3'd4) r_en <= ~r_en;
            else                    r_alarm <= inc_field(r_edit_sel, r_alarm);
          end
        end
        assign w_alarm_pad[gi] = r_alarm;
        assign w_en_pad[gi]    = r_en;
      end else begin : g_off
        assign w_alarm_pad[gi] = 16'h0000;
        assign w_en_pad[gi]    = 1'b0;
      end
      assign w_match[gi] = w_en_pad[gi] && (w_alarm_pad[gi] == w_time_nx[23:8]);
    end
  endgenerate

  // Lowest-numbered matching alarm wins
  always_comb begin
    w_ring_idx_new = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_match[i]) w_ring_idx_new = 2'(i);
    end
  end

  assign w_ring_start = w_adv && (w_time_nx[7:0] == 8'h00) && (|w_match);

  // Ring: starts on an alarm match, stops on any press or after RING_S ticks
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ring     <= 1'b0;
      r_ring_idx <= 2'd0;
      r_ring_cnt <= '0;
    end else if (r_ring) begin
      if (w_any_p) begin
        r_ring <= 1'b0;
      end else if (sec_tick) begin
        if (r_ring_cnt == RING_LAST) r_ring <= 1'b0;
        else                         r_ring_cnt <= r_ring_cnt + RING_W'(1);
      end
    end else if (w_ring_start) begin
      r_ring     <= 1'b1;
      r_ring_idx <= w_ring_idx_new;
      r_ring_cnt <= '0;
    end
  end

  // Stopwatch FSM: next state and clear request
  always_comb begin
    w_sw_state_next = r_sw_state;
    w_sw_clear      = 1'b0;
    if (r_state == ST_STOPWATCH) begin
      if (w_act_clr && (r_sw_state == SW_IDLE || r_sw_state == SW_STOP)) begin
        w_sw_clear      = 1'b1;
        w_sw_state_next = SW_IDLE;
      end else if (w_act_set) begin
        case (r_sw_state)
          SW_IDLE:  w_sw_state_next = SW_RUN;
          SW_RUN:   w_sw_state_next = SW_SPLIT;
          SW_SPLIT: w_sw_state_next = SW_STOP;
          SW_STOP:  w_sw_state_next = SW_RUN;
          default:  w_sw_state_next = SW_IDLE;
        endcase
      end
    end
  end

  assign w_sw_split_enter = (r_sw_state == SW_RUN) && (w_sw_state_next == SW_SPLIT);
  assign w_sw_counting    = (r_sw_state == SW_RUN) || (r_sw_state == SW_SPLIT);

  // Stopwatch state, live count and frozen split display
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sw_state   <= SW_IDLE;
      r_sw_mm      <= 7'd0;
      r_sw_ss      <= 6'd0;
      r_sw_disp_mm <= 7'd0;
      r_sw_disp_ss <= 6'd0;
    end else begin
      r_sw_state <= w_sw_state_next;
      if (w_sw_clear) begin
        r_sw_mm <= 7'd0;
        r_sw_ss <= 6'd0;
      end else if (sec_tick && w_sw_counting) begin
        if (r_sw_ss == 6'd59) begin
          r_sw_ss <= 6'd0;
          r_sw_mm <= (r_sw_mm == 7'd99) ? 7'd0 : r_sw_mm + 7'd1;
        end else begin
          r_sw_ss <= r_sw_ss + 6'd1;
        end
      end
      if (w_sw_split_enter) begin
        r_sw_disp_mm <= r_sw_mm;
        r_sw_disp_ss <= r_sw_ss;
      end
    end
  end

  assign w_disp_alarm = (r_state == ST_SET_ALARM) ? w_alarm_pad[r_alarm_idx] : w_alarm_pad[0];

  assign {hh_t, hh_u, mm_t, mm_u, ss_t, ss_u} = r_time;
  assign {ah_t, ah_u, am_t, am_u}             = w_disp_alarm;
  assign alarm_en     = w_en_pad[NUM_ALARMS-1:0];
  assign ring         = r_ring;
  assign ring_idx     = r_ring_idx;
  assign sw_mm        = (r_sw_state == SW_SPLIT) ? r_sw_disp_mm : r_sw_mm;
  assign sw_ss        = (r_sw_state == SW_SPLIT) ? r_sw_disp_ss : r_sw_ss;
  assign state_out    = r_state;
  assign edit_sel     = r_edit_sel;
  assign alarm_idx    = r_alarm_idx;
  assign sw_state_out = r_sw_state;

endmodule

// File: tb/tb_watch_ctrl_ma.sv
// Directed bench for watch_ctrl_ma: time setting, timeouts, alarms, ring,
// stopwatch and reset, with hand-computed expectations.
module tb_watch_ctrl_ma;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sec_tick = 1'b0;
  logic       mode_btn = 1'b0;
  logic       set_btn = 1'b0;
  logic       clr_btn = 1'b0;
  logic [3:0] hh_t, hh_u, mm_t, mm_u, ss_t, ss_u;
  logic [3:0] ah_t, ah_u, am_t, am_u;
  logic [1:0] alarm_en;
  logic       ring;
  logic [1:0] ring_idx;
  logic [6:0] sw_mm;
  logic [5:0] sw_ss;
  logic [1:0] state_out;
  logic [2:0] edit_sel;
  logic [1:0] alarm_idx;
  logic [1:0] sw_state_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] t_time;
  logic [15:0] t_alarm;
  assign t_time  = {hh_t, hh_u, mm_t, mm_u, ss_t, ss_u};
  assign t_alarm = {ah_t, ah_u, am_t, am_u};

  watch_ctrl_ma #(.NUM_ALARMS(2), .TIMEOUT_S(15), .RING_S(30)) dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick),
    .mode_btn(mode_btn), .set_btn(set_btn), .clr_btn(clr_btn),
    .hh_t(hh_t), .hh_u(hh_u), .mm_t(mm_t), .mm_u(mm_u), .ss_t(ss_t), .ss_u(ss_u),
    .ah_t(ah_t), .ah_u(ah_u), .am_t(am_t), .am_u(am_u),
    .alarm_en(alarm_en), .ring(ring), .ring_idx(ring_idx),
    .sw_mm(sw_mm), .sw_ss(sw_ss), .state_out(state_out),
    .edit_sel(edit_sel), .alarm_idx(alarm_idx), .sw_state_out(sw_state_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] check %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_mode();
    mode_btn = 1'b1; step(); mode_btn = 1'b0; step();
  endtask

  task automatic press_set();
    set_btn = 1'b1; step(); set_btn = 1'b0; step();
  endtask

  task automatic press_clr();
    clr_btn = 1'b1; step(); clr_btn = 1'b0; step();
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      sec_tick = 1'b1; step(); sec_tick = 1'b0;
    end
  endtask

  // From NORMAL: set the clock to 06:59 and leave via SET_ALARM (ss -> 00).
  task automatic set_0659();
    press_mode();
    for (int k = 0; k < 3 && hh_t != 4'd0; k++) press_set();
    press_mode();
    for (int k = 0; k < 10 && hh_u != 4'd6; k++) press_set();
    press_mode();
    for (int k = 0; k < 6 && mm_t != 4'd5; k++) press_set();
    press_mode();
    for (int k = 0; k < 10 && mm_u != 4'd9; k++) press_set();
    press_mode();
  endtask

  initial begin
    logic [3:0] hu_seq [5];
    hu_seq[0] = 4'd1; hu_seq[1] = 4'd2; hu_seq[2] = 4'd3; hu_seq[3] = 4'd0; hu_seq[4] = 4'd1;

    // Reset state
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("rst_state", state_out, 0);
    chk("rst_time", t_time, 24'h000000);
    chk("rst_alarm_en", alarm_en, 0);
    chk("rst_ring", {ring, ring_idx}, 0);
    chk("rst_sw", {sw_state_out, sw_mm, sw_ss}, 0);
    chk("rst_edit", {edit_sel, alarm_idx}, 0);
    chk("rst_alarm_disp", t_alarm, 16'h0000);

    // Time runs in NORMAL
    tick(7);
    chk("run_7s", t_time, 24'h000007);

    // hh_t 0->1->2, then hh_u limited to 0..3
    press_mode();
    chk("enter_set_time", {state_out, edit_sel}, {2'd1, 3'd0});
    press_set();
    chk("hh_t_1", hh_t, 1);
    press_set();
    chk("hh_t_2", hh_t, 2);
    press_mode();
    chk("edit_sel_1", edit_sel, 1);
    for (int k = 0; k < 5; k++) begin
      press_set();
      chk($sformatf("hh_u_wrap_%0d", k), hh_u, hu_seq[k]);
    end

    // Frozen while set, timeout after 15 idle ticks, ss cleared
    tick(14);
    chk("set_time_frozen", {state_out, t_time}, {2'd1, 24'h210007});
    tick(1);
    chk("timeout_state", {state_out, edit_sel, alarm_idx}, {2'd0, 3'd0, 2'd0});
    chk("timeout_kept_ss0", t_time, 24'h210000);

    // hh_u=9 with hh_t=1, then hh_t->2 clamps hh_u to 3 at once
    press_mode();
    press_set();
    chk("hh_wrap_0", {hh_t, hh_u}, 8'h01);
    press_set();
    chk("hh_1x", {hh_t, hh_u}, 8'h11);
    press_mode();
    repeat (8) press_set();
    chk("hh_19", {hh_t, hh_u}, 8'h19);
    tick(15);
    chk("timeout_2", state_out, 0);
    press_mode();
    press_set();
    chk("hh_clamp_23", {hh_t, hh_u}, 8'h23);
    repeat (4) press_mode();
    chk("enter_set_alarm", {state_out, alarm_idx, edit_sel}, {2'd2, 2'd0, 3'd0});

    // Alarm 1 = 07:00 enabled
    repeat (5) press_mode();
    chk("alarm_idx_1", {alarm_idx, edit_sel}, {2'd1, 3'd0});
    press_mode();
    repeat (7) press_set();
    chk("alarm1_disp", t_alarm, 16'h0700);
    repeat (3) press_mode();
    chk("edit_sel_en", edit_sel, 4);
    press_set();
    chk("alarm_en", alarm_en, 2'b10);
    press_mode();
    chk("enter_stopwatch", state_out, 3);
    chk("disp_alarm0", t_alarm, 16'h0000);
    press_mode();
    chk("back_normal", state_out, 0);

    // Ring at 07:00:00 from alarm 1, auto-stop after 30 ticks
    set_0659();
    tick(59);
    chk("pre_ring_time", {ring, state_out, t_time}, {1'b0, 2'd0, 24'h065959});
    tick(1);
    chk("ring_on", {ring, ring_idx, t_time}, {1'b1, 2'd1, 24'h070000});
    tick(29);
    chk("ring_still_on", ring, 1);
    tick(1);
    chk("ring_auto_off", ring, 0);

    // Stopwatch run / split / stop / clear
    repeat (15) press_mode();
    chk("sw_mode", {state_out, sw_state_out}, {2'd3, 2'd0});
    press_set();
    chk("sw_run", sw_state_out, 1);
    tick(5);
    chk("sw_5s", {sw_mm, sw_ss}, {7'd0, 6'd5});
    press_set();
    chk("sw_split", sw_state_out, 2);
    tick(3);
    chk("sw_split_frozen", {sw_mm, sw_ss}, {7'd0, 6'd5});
    press_set();
    chk("sw_stop", {sw_state_out, sw_mm, sw_ss}, {2'd3, 7'd0, 6'd8});
    press_clr();
    chk("sw_clear", {sw_state_out, sw_mm, sw_ss}, {2'd0, 7'd0, 6'd0});
    press_mode();
    chk("sw_exit", state_out, 0);

    // Mode and set together: only the cursor moves
    press_mode();
    mode_btn = 1'b1; set_btn = 1'b1; step();
    mode_btn = 1'b0; set_btn = 1'b0; step();
    chk("mode_priority", {state_out, edit_sel, hh_t, hh_u}, {2'd1, 3'd1, 8'h07});
    tick(15);
    chk("timeout_3", {state_out, t_time}, {2'd0, 24'h070000});

    // A press silences the ring and does nothing else
    set_0659();
    tick(60);
    chk("ring_on_2", {ring, ring_idx}, {1'b1, 2'd1});
    press_mode();
    chk("ring_press_off", {ring, state_out}, {1'b0, 2'd0});

    // Reset while ringing, with every input active
    set_0659();
    tick(60);
    chk("ring_on_3", ring, 1);
    rst = 1'b0; mode_btn = 1'b1; set_btn = 1'b1; clr_btn = 1'b1; sec_tick = 1'b1;
    step();
    chk("rst_ring_off", {ring, ring_idx}, 0);
    chk("rst_mid_time", t_time, 24'h000000);
    chk("rst_mid_ctrl", {state_out, edit_sel, alarm_idx, sw_state_out}, 0);
    chk("rst_mid_alarm", {alarm_en, t_alarm, sw_mm, sw_ss}, 0);
    mode_btn = 1'b0; set_btn = 1'b0; clr_btn = 1'b0; sec_tick = 1'b0; rst = 1'b1;
    step();
    chk("post_rst_state", {state_out, t_time}, {2'd0, 24'h000000});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
